// File: rtl/life_engine_ctrl.sv
// life_engine_ctrl: Game of Life board controller with SET/RUN/STOP control,
// parametrised board size, optional toroidal edges, rate divider,
// single-step and automatic halt on a stable or extinct board.
module life_engine_ctrl #(
   parameter int ROWS     = 16,
   parameter int COLS     = 16,
   parameter int GEN_W    = 16,
   parameter int TICK_DIV = 1
) (
   input  logic                     ClkPort,
   input  logic                     reset_n,
   input  logic                     btn_run,
   input  logic                     btn_step,
   input  logic                     btn_clear,
   input  logic                     btn_up,
   input  logic                     btn_down,
   input  logic                     btn_load,
   input  logic [COLS-1:0]          cell_row_i,
   input  logic                     wrap_en,
   output logic [ROWS*COLS-1:0]     board_o,
   output logic [GEN_W-1:0]         generation_cnt_o,
   output logic [1:0]               state_o,
   output logic [$clog2(ROWS)-1:0]  cursor_o,
   output logic                     stable_o,
   output logic                     extinct_o,
   output logic                     gen_valid_o
);

   localparam int CUR_W = $clog2(ROWS);
   localparam int DIV_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);
   localparam logic [CUR_W-1:0] LAST_ROW = CUR_W'(ROWS - 1);

   typedef enum logic [1:0] {
      ST_SET  = 2'b00,
      ST_RUN  = 2'b01,
      ST_STOP = 2'b10
   } state_t;

   state_t                  state_q, state_d;
   logic [DIV_W-1:0]        div_q, div_d;
   logic [ROWS*COLS-1:0]    board_d;
   logic [ROWS*COLS-1:0]    next_board;
   logic [GEN_W-1:0]        gen_d;
   logic [CUR_W-1:0]        cursor_d;
   logic                    stable_d, extinct_d, gen_valid_d;
   logic                    do_eval;

   assign state_o = state_q;

   // B3/S23 successor of the current board; off-board neighbours either wrap or count as dead
   always_comb begin : next_gen_calc
      int nbr;
      int rr;
      int cc;
      logic in_range;
      next_board = '0;
      nbr        = 0;
      rr         = 0;
      cc         = 0;
      in_range   = 1'b0;
      for (int r = 0; r < ROWS; r++) begin
         for (int c = 0; c < COLS; c++) begin
            nbr = 0;
            for (int dr = -1; dr <= 1; dr++) begin
               for (int dc = -1; dc <= 1; dc++) begin
                  if (dr != 0 || dc != 0) begin
                     rr       = r + dr;
                     cc       = c + dc;
                     in_range = 1'b1;
                     if (wrap_en) begin
                        if (rr < 0)          rr = rr + ROWS;
                        else if (rr >= ROWS) rr = rr - ROWS;
                        if (cc < 0)          cc = cc + COLS;
                        else if (cc >= COLS) cc = cc - COLS;
                     end else if (rr < 0 || rr >= ROWS || cc < 0 || cc >= COLS) begin
                        in_range = 1'b0;
                     end
                     if (in_range && board_o[rr*COLS + cc]) nbr = nbr + 1;
                  end
               end
            end
            next_board[r*COLS + c] = (nbr == 3) || (nbr == 2 && board_o[r*COLS + c]);
         end
      end
   end

   // Button decoding, divider and halt checks; clear outranks run, run outranks step, step outranks cursor/load
   always_comb begin : control_next
      state_d     = state_q;
      div_d       = div_q;
      board_d     = board_o;
      gen_d       = generation_cnt_o;
      cursor_d    = cursor_o;
      stable_d    = stable_o;
      extinct_d   = extinct_o;
      gen_valid_d = 1'b0;
      do_eval     = 1'b0;

      if (btn_clear) begin
         state_d   = ST_SET;
         board_d   = '0;
         gen_d     = '0;
         cursor_d  = '0;
         stable_d  = 1'b0;
         extinct_d = 1'b0;
         div_d     = '0;
      end else begin
         case (state_q)
            ST_SET: begin
               if (btn_run) begin
                  state_d   = ST_RUN;
                  stable_d  = 1'b0;
                  extinct_d = 1'b0;
                  div_d     = '0;
               end else if (!btn_step) begin
                  if (btn_up) begin
                     cursor_d = (cursor_o == '0) ? LAST_ROW : cursor_o - CUR_W'(1);
                  end else if (btn_down) begin
                     cursor_d = (cursor_o == LAST_ROW) ? '0 : cursor_o + CUR_W'(1);
                  end
                  if (btn_load) begin
                     board_d[cursor_o*COLS +: COLS] = cell_row_i;
                  end
               end
            end
            ST_RUN: begin
               if (btn_run) begin
                  state_d = ST_STOP;
               end else if (div_q == DIV_LAST) begin
                  div_d   = '0;
                  do_eval = 1'b1;
               end else begin
                  div_d = div_q + DIV_W'(1);
               end
            end
            ST_STOP: begin
               if (btn_run) begin
                  state_d   = ST_RUN;
                  stable_d  = 1'b0;
                  extinct_d = 1'b0;
               end else if (btn_step) begin
                  do_eval = 1'b1;
               end
            end
            default: begin
               state_d = ST_SET;
            end
         endcase

         if (do_eval) begin
            if (board_o == '0) begin
               extinct_d = 1'b1;
               stable_d  = 1'b0;
               state_d   = ST_STOP;
            end else if (next_board == board_o) begin
               stable_d  = 1'b1;
               extinct_d = 1'b0;
               state_d   = ST_STOP;
            end else begin
               board_d     = next_board;
               gen_d       = generation_cnt_o + GEN_W'(1);
               gen_valid_d = 1'b1;
            end
         end
      end
   end

   // State and output registers; reset aborts any generation in flight
   always_ff @(posedge ClkPort or negedge reset_n) begin
      if (!reset_n) begin
         state_q          <= ST_SET;
         div_q            <= '0;
         board_o          <= '0;
         generation_cnt_o <= '0;
         cursor_o         <= '0;
         stable_o         <= 1'b0;
         extinct_o        <= 1'b0;
         gen_valid_o      <= 1'b0;
      end else begin
         state_q          <= state_d;
         div_q            <= div_d;
         board_o          <= board_d;
         generation_cnt_o <= gen_d;
         cursor_o         <= cursor_d;
         stable_o         <= stable_d;
         extinct_o        <= extinct_d;
         gen_valid_o      <= gen_valid_d;
      end
   end

endmodule

// File: tb/tb_life_engine_ctrl.sv
// Directed testbench for life_engine_ctrl: one instance with TICK_DIV=1 and one
// with TICK_DIV=4, sharing all inputs.
module tb_life_engine_ctrl;

   localparam int ROWS = 16;
   localparam int COLS = 16;
   localparam int GEN_W = 16;

   localparam logic [5:0] B_CLEAR = 6'b100000;
   localparam logic [5:0] B_RUN   = 6'b010000;
   localparam logic [5:0] B_STEP  = 6'b001000;
   localparam logic [5:0] B_UP    = 6'b000100;
   localparam logic [5:0] B_DOWN  = 6'b000010;
   localparam logic [5:0] B_LOAD  = 6'b000001;

   logic clk = 1'b0;
   logic reset_n;
   logic btn_run, btn_step, btn_clear, btn_up, btn_down, btn_load;
   logic [COLS-1:0] cell_row;
   logic wrap_en;

   logic [ROWS*COLS-1:0] board1, board4;
   logic [GEN_W-1:0] gen1, gen4;
   logic [1:0] state1, state4;
   logic [3:0] cursor1, cursor4;
   logic stable1, stable4, extinct1, extinct4, valid1, valid4;

   int assert_count = 0;
   int fail_count = 0;
   int tb_cursor = 0;
   logic [ROWS*COLS-1:0] exp_board;

   life_engine_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .TICK_DIV(1)) dut1 (
      .ClkPort(clk), .reset_n(reset_n),
      .btn_run(btn_run), .btn_step(btn_step), .btn_clear(btn_clear),
      .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
      .cell_row_i(cell_row), .wrap_en(wrap_en),
      .board_o(board1), .generation_cnt_o(gen1), .state_o(state1), .cursor_o(cursor1),
      .stable_o(stable1), .extinct_o(extinct1), .gen_valid_o(valid1)
   );

   life_engine_ctrl #(.ROWS(ROWS), .COLS(COLS), .GEN_W(GEN_W), .TICK_DIV(4)) dut4 (
      .ClkPort(clk), .reset_n(reset_n),
      .btn_run(btn_run), .btn_step(btn_step), .btn_clear(btn_clear),
      .btn_up(btn_up), .btn_down(btn_down), .btn_load(btn_load),
      .cell_row_i(cell_row), .wrap_en(wrap_en),
      .board_o(board4), .generation_cnt_o(gen4), .state_o(state4), .cursor_o(cursor4),
      .stable_o(stable4), .extinct_o(extinct4), .gen_valid_o(valid4)
   );

   always #5 clk = ~clk;

   // Called at a negedge: hold the given buttons across one posedge, return at the next negedge
   task automatic applyStimulus(input logic [5:0] btns);
      {btn_clear, btn_run, btn_step, btn_up, btn_down, btn_load} = btns;
      @(negedge clk);
      {btn_clear, btn_run, btn_step, btn_up, btn_down, btn_load} = 6'b0;
   endtask

   task automatic checkOutput(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
      assert_count++;
      assert (observed === expected) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Moves the cursor down to the requested row, then loads the pattern there
   task automatic loadRow(input int row, input logic [COLS-1:0] pattern);
      while (tb_cursor != row) begin
         applyStimulus(B_DOWN);
         tb_cursor = (tb_cursor + 1) % ROWS;
      end
      cell_row = pattern;
      applyStimulus(B_LOAD);
   endtask

   task automatic clearAll();
      applyStimulus(B_CLEAR);
      tb_cursor = 0;
   endtask

   initial begin
      reset_n = 1'b0;
      {btn_clear, btn_run, btn_step, btn_up, btn_down, btn_load} = 6'b0;
      cell_row = '0;
      wrap_en = 1'b1;
      #12;
      checkOutput("reset_board", board1, '0);
      checkOutput("reset_gen", gen1, '0);
      checkOutput("reset_state", state1, 2'b00);
      checkOutput("reset_cursor", cursor1, '0);
      checkOutput("reset_flags", {stable1, extinct1}, 2'b00);
      checkOutput("reset_valid", valid1, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // cursor wraps from row 0 up to the last row
      applyStimulus(B_UP);
      checkOutput("cursor_up_wrap", cursor1, 4'd15);
      clearAll();
      checkOutput("clear_cursor", cursor1, '0);

      // glider: four generations shift it by one row and one column
      loadRow(7, 16'h0040);
      loadRow(8, 16'h0080);
      loadRow(9, 16'h00E0);
      exp_board = '0;
      exp_board[7*COLS +: COLS] = 16'h0040;
      exp_board[8*COLS +: COLS] = 16'h0080;
      exp_board[9*COLS +: COLS] = 16'h00E0;
      checkOutput("glider_loaded", board1, exp_board);
      applyStimulus(B_RUN);
      checkOutput("glider_run_state", state1, 2'b01);
      checkOutput("glider_run_valid0", valid1, 1'b0);
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("glider_valid_g%0d", k), valid1, 1'b1);
         checkOutput($sformatf("glider_cnt_g%0d", k), gen1, 16'(k));
      end
      applyStimulus(B_RUN);
      exp_board = '0;
      exp_board[8*COLS +: COLS]  = 16'h0080;
      exp_board[9*COLS +: COLS]  = 16'h0100;
      exp_board[10*COLS +: COLS] = 16'h01C0;
      checkOutput("glider_stop_state", state1, 2'b10);
      checkOutput("glider_stop_cnt", gen1, 16'd4);
      checkOutput("glider_shifted", board1, exp_board);

      // vertical blinker, stopped, then single-stepped twice
      clearAll();
      loadRow(4, 16'h0020);
      loadRow(5, 16'h0020);
      loadRow(6, 16'h0020);
      applyStimulus(B_RUN);
      applyStimulus(B_RUN);
      checkOutput("blink_stopped", state1, 2'b10);
      checkOutput("blink_cnt0", gen1, 16'd0);
      applyStimulus(B_STEP);
      exp_board = '0;
      exp_board[5*COLS +: COLS] = 16'h0070;
      checkOutput("blink_step1_board", board1, exp_board);
      checkOutput("blink_step1_valid", valid1, 1'b1);
      checkOutput("blink_step1_state", state1, 2'b10);
      applyStimulus(B_STEP);
      exp_board = '0;
      exp_board[4*COLS +: COLS] = 16'h0020;
      exp_board[5*COLS +: COLS] = 16'h0020;
      exp_board[6*COLS +: COLS] = 16'h0020;
      checkOutput("blink_step2_board", board1, exp_board);
      checkOutput("blink_step2_cnt", gen1, 16'd2);
      checkOutput("blink_step2_state", state1, 2'b10);

      // 2x2 block halts as stable on the first tick
      clearAll();
      loadRow(2, 16'h0006);
      loadRow(3, 16'h0006);
      exp_board = '0;
      exp_board[2*COLS +: COLS] = 16'h0006;
      exp_board[3*COLS +: COLS] = 16'h0006;
      applyStimulus(B_RUN);
      @(negedge clk);
      checkOutput("block_flags", {stable1, extinct1}, 2'b10);
      checkOutput("block_state", state1, 2'b10);
      checkOutput("block_cnt", gen1, 16'd0);
      checkOutput("block_board", board1, exp_board);
      checkOutput("block_valid", valid1, 1'b0);

      // single cell dies, then the empty board halts as extinct
      clearAll();
      loadRow(3, 16'h0010);
      applyStimulus(B_RUN);
      @(negedge clk);
      checkOutput("single_g1_board", board1, '0);
      checkOutput("single_g1_cnt", gen1, 16'd1);
      checkOutput("single_g1_valid", valid1, 1'b1);
      @(negedge clk);
      checkOutput("single_flags", {stable1, extinct1}, 2'b01);
      checkOutput("single_state", state1, 2'b10);
      checkOutput("single_cnt", gen1, 16'd1);
      checkOutput("single_valid", valid1, 1'b0);

      // horizontal blinker on row 0 with toroidal edges
      clearAll();
      wrap_en = 1'b1;
      loadRow(0, 16'h0007);
      applyStimulus(B_RUN);
      applyStimulus(B_RUN);
      applyStimulus(B_STEP);
      exp_board = '0;
      exp_board[15*COLS +: COLS] = 16'h0002;
      exp_board[0*COLS +: COLS]  = 16'h0002;
      exp_board[1*COLS +: COLS]  = 16'h0002;
      checkOutput("wrap_on_board", board1, exp_board);

      // same blinker with dead edges
      clearAll();
      wrap_en = 1'b0;
      loadRow(0, 16'h0007);
      applyStimulus(B_RUN);
      applyStimulus(B_RUN);
      applyStimulus(B_STEP);
      exp_board = '0;
      exp_board[0*COLS +: COLS] = 16'h0002;
      exp_board[1*COLS +: COLS] = 16'h0002;
      checkOutput("wrap_off_board", board1, exp_board);
      wrap_en = 1'b1;

      // divide-by-4 instance: generations only every fourth cycle
      clearAll();
      loadRow(4, 16'h0020);
      loadRow(5, 16'h0020);
      loadRow(6, 16'h0020);
      applyStimulus(B_RUN);
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         checkOutput($sformatf("div4_valid_c%0d", k), valid4, (k % 4 == 0) ? 1'b1 : 1'b0);
      end
      checkOutput("div4_cnt", gen4, 16'd2);
      checkOutput("div1_cnt", gen1, 16'd8);

      // run and clear in the same cycle: clear wins
      applyStimulus(B_RUN | B_CLEAR);
      tb_cursor = 0;
      checkOutput("runclr_state", state1, 2'b00);
      checkOutput("runclr_board", board1, '0);
      checkOutput("runclr_cnt", gen1, '0);
      checkOutput("runclr_state4", state4, 2'b00);
      checkOutput("runclr_cnt4", gen4, '0);

      // asynchronous reset in the middle of a run
      loadRow(5, 16'h0070);
      applyStimulus(B_RUN);
      @(negedge clk);
      @(negedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      checkOutput("async_board", board1, '0);
      checkOutput("async_cnt", gen1, '0);
      checkOutput("async_state", state1, 2'b00);
      checkOutput("async_valid", valid1, 1'b0);
      checkOutput("async_board4", board4, '0);
      checkOutput("async_state4", state4, 2'b00);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
      $finish;
   end

endmodule

// File: doc/life_engine_ctrl.md
Name: life_engine_ctrl

Overview:
- Parametrised successor to the fixed 16x16 Game of Life top controller. Owns the board register and the SET/RUN/STOP state machine, and computes each next generation internally under the B3/S23 rule.
- Adds a configurable board size, toroidal or dead-edge boundaries, a rate divider, single-step mode, and automatic halt when the board becomes stable or extinct.
- Sits between the debounced button/switch front end and the display driver.

Parameters:
- ROWS, 16, board height in cells (>=3).
- COLS, 16, board width in cells (>=3); also the width of the row-entry switch bus.
- GEN_W, 16, generation counter width.
- TICK_DIV, 1, clock cycles per generation while running (>=1; 1 = every cycle).

Ports:
- ClkPort  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- btn_run  in  1  single-cycle pulse; toggles RUN/STOP, or starts from SET.
- btn_step  in  1  single-cycle pulse; advances one generation while in STOP.
- btn_clear  in  1  single-cycle pulse; clears board and counter, returns to SET.
- btn_up  in  1  single-cycle pulse; cursor row -1 (SET only).
- btn_down  in  1  single-cycle pulse; cursor row +1 (SET only).
- btn_load  in  1  single-cycle pulse; writes cell_row_i into the cursor row (SET only).
- cell_row_i  in  COLS  row pattern; bit c = column c.
- wrap_en  in  1  1 = toroidal edges; 0 = off-board neighbours are dead.
- board_o  out  ROWS*COLS  current board; cell (r,c) = bit r*COLS+c.
- generation_cnt_o  out  GEN_W  generations computed since the last clear or reset.
- state_o  out  2  00 = SET, 01 = RUN, 10 = STOP.
- cursor_o  out  clog2(ROWS)  current entry row.
- stable_o  out  1  sticky; last halt was caused by next board == current board.
- extinct_o  out  1  sticky; last halt was caused by an all-zero board.
- gen_valid_o  out  1  one-cycle pulse in the cycle the board register updates with a new generation.

Behaviour:
- Reset (reset_n low, asynchronous): board_o = 0, generation_cnt_o = 0, state_o = SET, cursor_o = 0, stable_o = 0, extinct_o = 0, gen_valid_o = 0, divider = 0.
- Button priority when several pulse in the same cycle: clear > run > step > up/down/load. Lower-priority pulses in that cycle are ignored.
- SET:
  - up/down move the cursor, wrapping modulo ROWS (0-1 -> ROWS-1; ROWS-1+1 -> 0).
  - load writes cell_row_i into row cursor_o on the next edge.
  - run -> RUN, clears stable_o, extinct_o and the divider.
  - step is ignored.
- RUN:
  - The divider counts 0..TICK_DIV-1. At terminal count a "tick" occurs and the divider returns to 0.
  - On a tick, next generation N is computed combinationally from the board using the B3/S23 rule with 8 neighbours, edges per wrap_en.
  - Tick with board == 0: no update, no count, extinct_o = 1, -> STOP.
  - Else tick with N == board: no update, no count, stable_o = 1, -> STOP.
  - Otherwise: board <= N, generation_cnt_o += 1 (wraps modulo 2^GEN_W), gen_valid_o = 1 for that cycle.
  - Extinction is checked before stability.
  - run -> STOP with no tick that cycle; the divider holds its value.
- STOP:
  - step performs exactly one generation on the next edge, applying the same rule, halt checks, count and gen_valid_o pulse as a tick. The state stays STOP.
  - run -> RUN, clears stable_o and extinct_o, resumes the divider from its held value.
  - up/down/load are ignored.
- clear (any state): board = 0, generation_cnt_o = 0, cursor = 0, flags = 0, divider = 0, -> SET.
- wrap_en is sampled at every evaluation; changing it mid-run affects the next generation only.
- All outputs are registered. board_o reflects a write one edge after load or tick.
- Reset asserted mid-generation aborts it; no partial board update is allowed.

Test Plan:
- Reset, then SET, load rows 7/8/9 of a 16x16 board with a glider, run with TICK_DIV=1 -> gen_valid_o pulses every cycle; after 4 generations the glider is shifted (+1,+1) and generation_cnt_o = 4.
- Vertical blinker at column 5, rows 4-6; stop, then step twice -> horizontal, then vertical again; generation_cnt_o = 2; state stays STOP.
- 2x2 block, run -> first tick halts: stable_o = 1, state_o = STOP, generation_cnt_o = 0, board unchanged.
- Single live cell, run -> generation 1 becomes an empty board (count = 1); the next tick sets extinct_o = 1 and goes to STOP with count = 1.
- Horizontal blinker on row 0, columns 0-2: with wrap_en = 1, gen 1 has cells at rows ROWS-1/0/1, column 1; with wrap_en = 0, gen 1 has only rows 0/1, column 1.
- TICK_DIV=4: gen_valid_o pulses every 4th cycle. run+clear in the same cycle -> SET with everything zeroed. Cursor at 0 with btn_up -> ROWS-1. Asserting reset_n low mid-RUN zeroes all outputs immediately, without waiting for a clock edge.
